// File: rtl/button_repeat_pulser.sv
// Push-button conditioner for the clock's time-set inputs.
// Synchronises and debounces one raw button, emits a single-cycle `pulse`
// per confirmed press, and auto-repeats that pulse while the button is held.
// Every output is registered, so there is no combinational path from btn_raw.
module button_repeat_pulser #(
    parameter int DEBOUNCE_CYCLES = 216000,
    parameter int HOLD_CYCLES     = 13500000,
    parameter int REPEAT_CYCLES   = 2700000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic enable,
    output logic pulse,
    output logic held,
    output logic repeating
);

    localparam int MAX_DH     = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYCLES = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

    // Level the pin rests at when the button is not pressed.
    localparam logic IDLE_LEVEL = ACTIVE_LOW ? 1'b1 : 1'b0;

    // A terminal count of 0 or 1 would make the debounce/hold windows meaningless.
    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("button_repeat_pulser: all cycle parameters must be >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEB_PRESS,
        S_HOLD,
        S_REPEAT,
        S_DEB_RELEASE
    } state_t;

    logic          sync1;
    logic          sync2;
    logic          pressed;
    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          fire;

    // Two-flop synchroniser; resets to the released level so no phantom press appears.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so sync2 takes the old sync1, forming a real two-stage chain.
        if (reset) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    assign pressed = sync2 ^ IDLE_LEVEL;

    // Next-state, shared-counter and terminal-event logic; a release always wins over a terminal count.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_n = state;
        cnt_n   = cnt;
        fire    = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (pressed) state_n = S_DEB_PRESS;
            end
            S_DEB_PRESS: begin
                if (!pressed) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = S_HOLD;
                    cnt_n   = '0;
                    fire    = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_HOLD: begin
                if (!pressed) begin
                    state_n = S_DEB_RELEASE;
                    cnt_n   = '0;
                end else if (cnt == HOLD_LAST) begin
                    if (REPEAT_EN) begin
                        state_n = S_REPEAT;
                        cnt_n   = '0;
                        fire    = 1'b1;
                    end else begin
                        cnt_n = cnt;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_REPEAT: begin
                if (!pressed) begin
                    state_n = S_DEB_RELEASE;
                    cnt_n   = '0;
                end else if (cnt == REP_LAST) begin
                    cnt_n = '0;
                    fire  = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_DEB_RELEASE: begin
                if (pressed) begin
                    state_n = S_HOLD;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; enable only masks the strobe, never the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            pulse     <= 1'b0;
            held      <= 1'b0;
            repeating <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pulse     <= fire & enable;
            held      <= (state_n == S_HOLD) || (state_n == S_REPEAT) || (state_n == S_DEB_RELEASE);
            repeating <= (state_n == S_REPEAT);
        end
    end

endmodule

// File: tb/tb_button_repeat_pulser.sv
// Bench for button_repeat_pulser with short timing parameters.
// Expected pulse edges are queued as stimulus is applied and matched by a
// monitor as pulses appear; each scenario task checks held/repeating inline.
module tb_button_repeat_pulser;

    logic clk = 1'b0;
    logic reset;
    logic btn_raw;
    logic enable;
    logic pulse;
    logic held;
    logic repeating;

    int edge_no  = 0;
    int n_checks = 0;
    int n_pass   = 0;
    int sb[$];

    button_repeat_pulser #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (20),
        .REPEAT_CYCLES  (8),
        .ACTIVE_LOW     (1'b1),
        .REPEAT_EN      (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .enable   (enable),
        .pulse    (pulse),
        .held     (held),
        .repeating(repeating)
    );

    always #5 clk = ~clk;

    // Number of the most recent rising edge.
    always @(posedge clk) edge_no <= edge_no + 1;

    // Scoreboard consumer: every pulse must match the oldest expected edge; stale entries are misses.
    always @(negedge clk) begin
        int exp_edge;
        if (sb.size() > 0 && sb[0] < edge_no) begin
            exp_edge = sb.pop_front();
            n_checks++;
            $display("FAIL pulse_missed: no pulse at edge %0d, now at edge %0d", exp_edge, edge_no);
        end
        if (pulse === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL pulse_unexpected: pulse at edge %0d, none expected", edge_no);
            end else begin
                exp_edge = sb.pop_front();
                if (edge_no !== exp_edge)
                    $display("FAIL pulse_edge: pulse at edge %0d, expected edge %0d", edge_no, exp_edge);
                else
                    n_pass++;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_no);
        $fatal(1, "watchdog");
    end

    task automatic wait_edge(input int e);
        while (edge_no < e) @(negedge clk);
    endtask

    task automatic test_reset();
        for (int e = 1; e <= 3; e++) begin
            wait_edge(e);
            n_checks++;
            if ({pulse, held, repeating} !== 3'b000)
                $display("FAIL reset_outputs edge %0d: got %b want 000", e, {pulse, held, repeating});
            else
                n_pass++;
        end
        reset = 1'b0;
        wait_edge(8);
        n_checks++;
        if ({pulse, held, repeating} !== 3'b000)
            $display("FAIL idle_after_reset: got %b want 000", {pulse, held, repeating});
        else
            n_pass++;
    endtask

    task automatic test_clean_press();
        int t, r;
        t = edge_no + 1;
        sb.push_back(t + 6);
        btn_raw = 1'b0;
        wait_edge(t + 5);
        n_checks++;
        if ({held, repeating} !== 2'b00) $display("FAIL t1_before_pulse: got %b want 00", {held, repeating});
        else n_pass++;
        wait_edge(t + 6);
        n_checks++;
        if ({held, repeating} !== 2'b10) $display("FAIL t1_held_on: got %b want 10", {held, repeating});
        else n_pass++;
        wait_edge(t + 11);
        btn_raw = 1'b1;
        r = t + 12;
        wait_edge(r + 5);
        n_checks++;
        if ({held, repeating} !== 2'b10) $display("FAIL t1_release_debounce: got %b want 10", {held, repeating});
        else n_pass++;
        wait_edge(r + 6);
        n_checks++;
        if ({held, repeating} !== 2'b00) $display("FAIL t1_back_to_idle: got %b want 00", {held, repeating});
        else n_pass++;
        wait_edge(r + 10);
        n_checks++;
        if (sb.size() !== 0) $display("FAIL t1_sb_drained: %0d pending, want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_press_bounce();
        int s, r;
        // Samples: s..s+2 pressed, s+3 released, s+4 onward pressed.
        s = edge_no + 1;
        btn_raw = 1'b0;
        wait_edge(s + 2);
        btn_raw = 1'b1;
        wait_edge(s + 3);
        btn_raw = 1'b0;
        sb.push_back(s + 10);
        wait_edge(s + 5);
        n_checks++;
        if ({held, repeating} !== 2'b00) $display("FAIL t2_bounce_rejected: got %b want 00", {held, repeating});
        else n_pass++;
        wait_edge(s + 9);
        n_checks++;
        if ({held, repeating} !== 2'b00) $display("FAIL t2_still_debouncing: got %b want 00", {held, repeating});
        else n_pass++;
        wait_edge(s + 10);
        n_checks++;
        if ({held, repeating} !== 2'b10) $display("FAIL t2_held_on: got %b want 10", {held, repeating});
        else n_pass++;
        wait_edge(s + 14);
        btn_raw = 1'b1;
        r = s + 15;
        wait_edge(r + 6);
        n_checks++;
        if ({held, repeating} !== 2'b00) $display("FAIL t2_back_to_idle: got %b want 00", {held, repeating});
        else n_pass++;
        wait_edge(r + 10);
        n_checks++;
        if (sb.size() !== 0) $display("FAIL t2_sb_drained: %0d pending, want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_hold_repeat();
        int t;
        t = edge_no + 1;
        sb.push_back(t + 6);
        sb.push_back(t + 26);
        for (int k = 0; k < 5; k++) sb.push_back(t + 34 + 8 * k);
        btn_raw = 1'b0;
        wait_edge(t + 25);
        n_checks++;
        if ({held, repeating} !== 2'b10) $display("FAIL t3_before_repeat: got %b want 10", {held, repeating});
        else n_pass++;
        wait_edge(t + 26);
        n_checks++;
        if ({held, repeating} !== 2'b11) $display("FAIL t3_repeat_on: got %b want 11", {held, repeating});
        else n_pass++;
        wait_edge(t + 69);
        btn_raw = 1'b1;
        wait_edge(t + 71);
        n_checks++;
        if ({held, repeating} !== 2'b11) $display("FAIL t3_repeat_until_release: got %b want 11", {held, repeating});
        else n_pass++;
        wait_edge(t + 72);
        n_checks++;
        if ({held, repeating} !== 2'b10) $display("FAIL t3_release_debounce: got %b want 10", {held, repeating});
        else n_pass++;
        wait_edge(t + 76);
        n_checks++;
        if ({held, repeating} !== 2'b00) $display("FAIL t3_back_to_idle: got %b want 00", {held, repeating});
        else n_pass++;
        wait_edge(t + 80);
        n_checks++;
        if (sb.size() !== 0) $display("FAIL t3_sb_drained: %0d pending, want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_release_glitch();
        int t, r;
        t = edge_no + 1;
        sb.push_back(t + 6);
        btn_raw = 1'b0;
        wait_edge(t + 11);
        btn_raw = 1'b1;
        r = t + 12;
        // One pressed sample at edge r+2, while the release is being debounced.
        wait_edge(r + 1);
        btn_raw = 1'b0;
        wait_edge(r + 2);
        btn_raw = 1'b1;
        n_checks++;
        if ({held, repeating} !== 2'b10) $display("FAIL t4_in_release: got %b want 10", {held, repeating});
        else n_pass++;
        wait_edge(r + 4);
        n_checks++;
        if ({held, repeating} !== 2'b10) $display("FAIL t4_glitch_absorbed: got %b want 10", {held, repeating});
        else n_pass++;
        wait_edge(r + 8);
        n_checks++;
        if ({held, repeating} !== 2'b10) $display("FAIL t4_redebounce: got %b want 10", {held, repeating});
        else n_pass++;
        wait_edge(r + 9);
        n_checks++;
        if ({held, repeating} !== 2'b00) $display("FAIL t4_back_to_idle: got %b want 00", {held, repeating});
        else n_pass++;
        wait_edge(r + 12);
        n_checks++;
        if (sb.size() !== 0) $display("FAIL t4_sb_drained: %0d pending, want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_enable_mask();
        int t;
        t = edge_no + 1;
        enable  = 1'b0;
        btn_raw = 1'b0;
        sb.push_back(t + 34);
        sb.push_back(t + 42);
        wait_edge(t + 6);
        n_checks++;
        if ({held, repeating} !== 2'b10) $display("FAIL t5_held_masked: got %b want 10", {held, repeating});
        else n_pass++;
        wait_edge(t + 26);
        n_checks++;
        if ({held, repeating} !== 2'b11) $display("FAIL t5_repeat_masked: got %b want 11", {held, repeating});
        else n_pass++;
        wait_edge(t + 30);
        enable = 1'b1;
        wait_edge(t + 43);
        btn_raw = 1'b1;
        wait_edge(t + 46);
        n_checks++;
        if ({held, repeating} !== 2'b10) $display("FAIL t5_release_debounce: got %b want 10", {held, repeating});
        else n_pass++;
        wait_edge(t + 50);
        n_checks++;
        if ({held, repeating} !== 2'b00) $display("FAIL t5_back_to_idle: got %b want 00", {held, repeating});
        else n_pass++;
        wait_edge(t + 54);
        n_checks++;
        if (sb.size() !== 0) $display("FAIL t5_sb_drained: %0d pending, want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_hold();
        int t, tp;
        t = edge_no + 1;
        btn_raw = 1'b0;
        sb.push_back(t + 6);
        sb.push_back(t + 26);
        wait_edge(t + 29);
        reset = 1'b1;
        for (int e = t + 30; e <= t + 32; e++) begin
            wait_edge(e);
            n_checks++;
            if ({pulse, held, repeating} !== 3'b000)
                $display("FAIL t6_in_reset edge %0d: got %b want 000", e - t, {pulse, held, repeating});
            else
                n_pass++;
        end
        reset = 1'b0;
        tp = t + 33;
        sb.push_back(tp + 6);
        sb.push_back(tp + 26);
        sb.push_back(tp + 34);
        wait_edge(tp);
        n_checks++;
        if ({pulse, held, repeating} !== 3'b000)
            $display("FAIL t6_after_reset: got %b want 000", {pulse, held, repeating});
        else
            n_pass++;
        wait_edge(tp + 5);
        n_checks++;
        if ({held, repeating} !== 2'b00) $display("FAIL t6_redebounce: got %b want 00", {held, repeating});
        else n_pass++;
        wait_edge(tp + 6);
        n_checks++;
        if ({held, repeating} !== 2'b10) $display("FAIL t6_fresh_hold: got %b want 10", {held, repeating});
        else n_pass++;
        wait_edge(tp + 26);
        n_checks++;
        if ({held, repeating} !== 2'b11) $display("FAIL t6_repeat_restart: got %b want 11", {held, repeating});
        else n_pass++;
        wait_edge(tp + 35);
        btn_raw = 1'b1;
        wait_edge(tp + 42);
        n_checks++;
        if ({held, repeating} !== 2'b00) $display("FAIL t6_back_to_idle: got %b want 00", {held, repeating});
        else n_pass++;
        wait_edge(tp + 46);
        n_checks++;
        if (sb.size() !== 0) $display("FAIL t6_sb_drained: %0d pending, want 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = 1'b1;
        enable  = 1'b1;
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_hold_repeat();
        test_release_glitch();
        test_enable_mask();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
